// File: rtl/nano_dsi_data_pkg.sv
// Shared DSI lane definitions: state encodings, timer trigger, sync/EoTp bytes, LP levels.
// Used by the data lane, its timer and the byte-stream interface.
package nano_dsi_data_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;
   localparam int unsigned STATE_W   = 3;
   localparam int unsigned EOTP_IDX_W = 2;

   localparam logic [STATE_W-1:0] ST_LP11     = 3'd0;
   localparam logic [STATE_W-1:0] ST_LP01     = 3'd1;
   localparam logic [STATE_W-1:0] ST_LP00     = 3'd2;
   localparam logic [STATE_W-1:0] ST_HS_ZERO  = 3'd3;
   localparam logic [STATE_W-1:0] ST_HS_SYNC  = 3'd4;
   localparam logic [STATE_W-1:0] ST_HS_DATA  = 3'd5;
   localparam logic [STATE_W-1:0] ST_EOTP     = 3'd6;
   localparam logic [STATE_W-1:0] ST_HS_TRAIL = 3'd7;

   localparam logic [BYTE_W-1:0] TIMER_TRIG = 8'h80;
   localparam logic [BYTE_W-1:0] SYNC_BYTE  = 8'hB8;

   // LP pairs are {Dp, Dn}
   localparam logic [1:0] LP_11 = 2'b11;
   localparam logic [1:0] LP_01 = 2'b01;
   localparam logic [1:0] LP_00 = 2'b00;

   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              last;
   } dsi_beat_t;

   function automatic logic [BYTE_W-1:0] eotp_byte(input logic [EOTP_IDX_W-1:0] idx);
      logic [BYTE_W-1:0] b;
      case (idx)
         2'd0:    b = 8'h08;
         2'd1:    b = 8'h0F;
         2'd2:    b = 8'h0F;
         default: b = 8'h01;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/nano_dsi_data_if.sv
// Payload byte stream from the packet builder to the data lane (valid/ready).
interface nano_dsi_data_if;
   import nano_dsi_data_pkg::*;

   dsi_beat_t in_beat;
   logic      in_valid;
   logic      in_ready;

   modport master (output in_beat, output in_valid, input in_ready);
   modport slave  (input in_beat, input in_valid, output in_ready);

endinterface

// File: rtl/nano_dsi_lane_timer.sv
// Lane dwell timer: load on state entry, decrement each cycle, trigger on bit 7.
module nano_dsi_lane_timer
   import nano_dsi_data_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [BYTE_W-1:0] load_val_i,
   output logic              trig_o
);

   logic [BYTE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = load_i ? load_val_i : cnt_q - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign trig_o = (cnt_q & TIMER_TRIG) != '0;

endmodule

// File: rtl/nano_dsi_data.sv
// DSI data-lane driver: LP-11/01/00 HS entry, HS-zero, sync, LSB-first payload, HS-trail.
// Build option NANO_DSI_DATA_EOTP_EN appends the EoT short packet before the trail.
module nano_dsi_data
   import nano_dsi_data_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic              data_lp_p,
   output logic              data_lp_n,
   output logic              data_hs_p,
   output logic              data_hs_n,
   output logic              data_hs_oe,
   input  logic              clk_sync,
   input  logic              pkt_req,
   output logic              pkt_busy,
   nano_dsi_data_if.slave    in_bus,
   output logic              err_underrun,
   input  logic [BYTE_W-1:0] cfg_lpx,
   input  logic [BYTE_W-1:0] cfg_hs_prep,
   input  logic [BYTE_W-1:0] cfg_hs_zero,
   input  logic [BYTE_W-1:0] cfg_hs_trail
);

   logic [STATE_W-1:0]   state_q, state_d;
   logic [BYTE_W-1:0]    sh_q, sh_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                 last_q, last_d;
   logic                 bit_q, bit_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 rdy_q, rdy_d;
`ifdef NANO_DSI_DATA_EOTP_EN
   logic [EOTP_IDX_W-1:0] eidx_q, eidx_d;
`endif
   logic [1:0]           lp_q, lp_d;
   logic                 oe_q, oe_d, hs_q, hs_d, hsn_q, hsn_d;
   logic                 tmr_load, tmr_trig;
   logic [BYTE_W-1:0]    tmr_val;

   nano_dsi_lane_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .trig_o     (tmr_trig)
   );

   // Next state, byte fetch and the values for the registered IO
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      bit_d   = bit_q;
      err_d   = err_q;
`ifdef NANO_DSI_DATA_EOTP_EN
      eidx_d  = eidx_q;
`endif
      case (state_q)
         ST_LP11:    if (pkt_req)  state_d = ST_LP01;
         ST_LP01:    if (tmr_trig) state_d = ST_LP00;
         ST_LP00:    if (tmr_trig) state_d = ST_HS_ZERO;
         ST_HS_ZERO: if (tmr_trig && !clk_sync) begin
            state_d = ST_HS_SYNC;
            sh_d    = SYNC_BYTE;
            cnt_d   = '0;
         end
         ST_HS_SYNC, ST_HS_DATA: begin
            bit_d = sh_q[0];
            if (cnt_q != 3'd7) begin
               sh_d  = sh_q >> 1;
               cnt_d = cnt_q + 3'd1;
            end else if (state_q == ST_HS_DATA && last_q) begin
`ifdef NANO_DSI_DATA_EOTP_EN
               state_d = ST_EOTP;
               sh_d    = eotp_byte(2'd0);
               cnt_d   = '0;
               eidx_d  = '0;
`else
               state_d = ST_HS_TRAIL;
`endif
            end else if (in_bus.in_valid) begin
               state_d = ST_HS_DATA;
               sh_d    = in_bus.in_beat.data;
               last_d  = in_bus.in_beat.last;
               cnt_d   = '0;
            end else begin
               err_d   = 1'b1;
               state_d = ST_HS_TRAIL;
            end
         end
`ifdef NANO_DSI_DATA_EOTP_EN
         ST_EOTP: begin
            bit_d = sh_q[0];
            if (cnt_q != 3'd7) begin
               sh_d  = sh_q >> 1;
               cnt_d = cnt_q + 3'd1;
            end else if (eidx_q == 2'd3) begin
               state_d = ST_HS_TRAIL;
            end else begin
               eidx_d = eidx_q + 2'd1;
               sh_d   = eotp_byte(eidx_q + 2'd1);
               cnt_d  = '0;
            end
         end
`endif
         ST_HS_TRAIL: if (tmr_trig) state_d = ST_LP11;
         default:     state_d = ST_LP11;
      endcase

      busy_d = state_d != ST_LP11;
      // Ready is precomputed so it sits high exactly on the fetch cycle (bit 7)
      rdy_d  = (state_d == ST_HS_SYNC || (state_d == ST_HS_DATA && !last_d)) && cnt_d == 3'd7;

      tmr_load = state_d != state_q;
      case (state_d)
         ST_LP01:     tmr_val = cfg_lpx;
         ST_LP00:     tmr_val = cfg_hs_prep;
         ST_HS_ZERO:  tmr_val = cfg_hs_zero;
         ST_HS_TRAIL: tmr_val = cfg_hs_trail;
         default:     tmr_val = '0;
      endcase

      lp_d = LP_00;
      oe_d = 1'b1;
      hs_d = 1'b0;
      case (state_q)
         ST_LP11: begin lp_d = LP_11; oe_d = 1'b0; end
         ST_LP01: begin lp_d = LP_01; oe_d = 1'b0; end
         ST_LP00: oe_d = 1'b0;
         ST_HS_SYNC, ST_HS_DATA, ST_EOTP: hs_d = sh_q[0];
         ST_HS_TRAIL: hs_d = ~bit_q;
         default: hs_d = 1'b0;
      endcase
      hsn_d = oe_d & ~hs_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LP11;
         sh_q    <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         bit_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef NANO_DSI_DATA_EOTP_EN
         eidx_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
`ifdef NANO_DSI_DATA_EOTP_EN
         eidx_q  <= eidx_d;
`endif
      end
   end

   // IO flops follow the state one cycle late; reset reaches them through the state
   always_ff @(posedge clk) begin
      lp_q  <= lp_d;
      oe_q  <= oe_d;
      hs_q  <= hs_d;
      hsn_q <= hsn_d;
   end

   assign data_lp_p       = lp_q[1];
   assign data_lp_n       = lp_q[0];
   assign data_hs_oe      = oe_q;
   assign data_hs_p       = hs_q;
   assign data_hs_n       = hsn_q;
   assign pkt_busy        = busy_q;
   assign err_underrun    = err_q;
   assign in_bus.in_ready = rdy_q;

endmodule

// File: tb/tb_nano_dsi_data.sv
// Directed bench for nano_dsi_data: burst table plus back-to-back and mid-burst reset sequences.
module tb_nano_dsi_data;
   import nano_dsi_data_pkg::*;

   logic       clk = 1'b0;
   logic       rst, clk_sync, pkt_req;
   logic [7:0] cfg_lpx, cfg_hs_prep, cfg_hs_zero, cfg_hs_trail;
   logic       data_lp_p, data_lp_n, data_hs_p, data_hs_n, data_hs_oe;
   logic       pkt_busy, err_underrun;

   nano_dsi_data_if bus ();

   nano_dsi_data dut (
      .clk          (clk),
      .rst          (rst),
      .data_lp_p    (data_lp_p),
      .data_lp_n    (data_lp_n),
      .data_hs_p    (data_hs_p),
      .data_hs_n    (data_hs_n),
      .data_hs_oe   (data_hs_oe),
      .clk_sync     (clk_sync),
      .pkt_req      (pkt_req),
      .pkt_busy     (pkt_busy),
      .in_bus       (bus),
      .err_underrun (err_underrun),
      .cfg_lpx      (cfg_lpx),
      .cfg_hs_prep  (cfg_hs_prep),
      .cfg_hs_zero  (cfg_hs_zero),
      .cfg_hs_trail (cfg_hs_trail)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] lp;
      logic oe, hp, hn, rdy, busy, err;
   } obs_t;

   typedef struct {
      logic [7:0]  lpx, prep, zero, trail;
      logic        p0;
      int          n;
      logic [23:0] bytes;
      int          drop_at;
      int          exp_lp01, exp_lp00, exp_zero, exp_trail, exp_rdy, exp_err, nsent;
      logic        exp_lvl;
   } vec_t;

   obs_t log_q[$];
   bit   log_en = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[4];

   always @(posedge clk) begin
      #1;
      if (log_en)
         log_q.push_back('{lp: {data_lp_p, data_lp_n}, oe: data_hs_oe, hp: data_hs_p,
                           hn: data_hs_n, rdy: bus.in_ready, busy: pkt_busy, err: err_underrun});
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pkt_req = 1'b0; clk_sync = 1'b0;
      bus.in_valid = 1'b0; bus.in_beat = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_idle(input string p);
      @(posedge clk); #1;
      check({p, "_lp"},   int'({data_lp_p, data_lp_n}), 3);
      check({p, "_oe"},   int'(data_hs_oe), 0);
      check({p, "_hs"},   int'({data_hs_p, data_hs_n}), 0);
      check({p, "_rdy"},  int'(bus.in_ready), 0);
      check({p, "_busy"}, int'(pkt_busy), 0);
      check({p, "_err"},  int'(err_underrun), 0);
   endtask

   task automatic drive_beat(input vec_t v, input int idx);
      bus.in_valid       = (idx < v.n) && (idx != v.drop_at);
      bus.in_beat.data   = 8'(v.bytes >> (8 * idx));
      bus.in_beat.last   = (idx == v.n - 1);
   endtask

   task automatic run_vec(input vec_t v, input int vi);
      bit         exp_s[$];
      bit         act_s[$];
      int         idx, tail, n01, n00, nrdy, nmis, nhn, first;
      bit         took, seen;
      logic       lvl;
      logic [7:0] s, b;
      logic [31:0] eot;
      string      p;
      p = $sformatf("r%0d", vi);
      do_reset();
      cfg_lpx = v.lpx; cfg_hs_prep = v.prep; cfg_hs_zero = v.zero; cfg_hs_trail = v.trail;
      log_q.delete();
      idx = 0; took = 1'b0; seen = 1'b0; tail = 0;
      @(negedge clk);
      clk_sync = v.p0; pkt_req = 1'b1; log_en = 1'b1;
      drive_beat(v, idx);
      for (int c = 0; c < 400 && tail < 3; c++) begin
         @(negedge clk);
         clk_sync = ~clk_sync;
         if (took) idx++;
         drive_beat(v, idx);
         took = bus.in_ready && bus.in_valid;
         if (pkt_busy) begin
            seen = 1'b1;
            pkt_req = 1'b0;
         end else if (seen) tail++;
      end
      log_en = 1'b0;
      bus.in_valid = 1'b0;
      check({p, "_end"}, tail, 3);

      n01 = 0; n00 = 0; nrdy = 0; nhn = 0;
      foreach (log_q[i]) begin
         if (log_q[i].lp == 2'b01) n01++;
         if (log_q[i].lp == 2'b00 && !log_q[i].oe) n00++;
         if (log_q[i].rdy) nrdy++;
         if (log_q[i].oe) begin
            act_s.push_back(log_q[i].hp);
            if (log_q[i].hn == log_q[i].hp) nhn++;
         end
      end

      for (int i = 0; i < v.exp_zero; i++) exp_s.push_back(1'b0);
      s = 8'hB8;
      for (int i = 0; i < 8; i++) exp_s.push_back(s[i]);
      for (int k = 0; k < v.nsent; k++) begin
         b = 8'(v.bytes >> (8 * k));
         for (int i = 0; i < 8; i++) exp_s.push_back(b[i]);
      end
      lvl = v.exp_lvl;
`ifdef NANO_DSI_DATA_EOTP_EN
      if (v.exp_err == 0) begin
         eot = 32'h010F0F08;
         for (int i = 0; i < 32; i++) exp_s.push_back(eot[i]);
         lvl = 1'b1;
      end
`endif
      for (int i = 0; i < v.exp_trail; i++) exp_s.push_back(lvl);

      nmis = 0; first = -1;
      for (int i = 0; i < exp_s.size() && i < act_s.size(); i++)
         if (exp_s[i] != act_s[i]) begin
            nmis++;
            if (first < 0) first = i;
         end
      check({p, "_lp01_len"}, n01, v.exp_lp01);
      check({p, "_lp00_len"}, n00, v.exp_lp00);
      check({p, "_hs_len"}, act_s.size(), exp_s.size());
      check($sformatf("%s_hs_bits(first_bad=%0d)", p, first), nmis, 0);
      check({p, "_hs_n"}, nhn, 0);
      check({p, "_rdy_pulses"}, nrdy, v.exp_rdy);
      check({p, "_err"}, int'(log_q[log_q.size()-1].err), v.exp_err);
      check({p, "_lp_back"}, int'(log_q[log_q.size()-1].lp), 3);
   endtask

   initial begin
      int i0, i1, lowlen, rises, j, lp11len;
      rst = 1'b1; pkt_req = 1'b0; clk_sync = 1'b0;
      cfg_lpx = '0; cfg_hs_prep = '0; cfg_hs_zero = '0; cfg_hs_trail = '0;
      bus.in_valid = 1'b0; bus.in_beat = '0;

      vecs[0] = '{lpx: 8'd2, prep: 8'd3, zero: 8'd5, trail: 8'd4, p0: 1'b0, n: 3,
                  bytes: 24'h813CA5, drop_at: -1, exp_lp01: 4, exp_lp00: 5, exp_zero: 7,
                  exp_trail: 6, exp_rdy: 3, exp_err: 0, nsent: 3, exp_lvl: 1'b0};
      vecs[1] = '{lpx: 8'd2, prep: 8'd3, zero: 8'd5, trail: 8'd4, p0: 1'b1, n: 1,
                  bytes: 24'h00002C, drop_at: -1, exp_lp01: 4, exp_lp00: 5, exp_zero: 8,
                  exp_trail: 6, exp_rdy: 1, exp_err: 0, nsent: 1, exp_lvl: 1'b1};
      vecs[2] = '{lpx: 8'd200, prep: 8'd128, zero: 8'd130, trail: 8'd255, p0: 1'b1, n: 2,
                  bytes: 24'h00FF00, drop_at: -1, exp_lp01: 1, exp_lp00: 1, exp_zero: 1,
                  exp_trail: 1, exp_rdy: 2, exp_err: 0, nsent: 2, exp_lvl: 1'b0};
      vecs[3] = '{lpx: 8'd1, prep: 8'd0, zero: 8'd2, trail: 8'd1, p0: 1'b1, n: 2,
                  bytes: 24'h002211, drop_at: 1, exp_lp01: 3, exp_lp00: 2, exp_zero: 4,
                  exp_trail: 3, exp_rdy: 2, exp_err: 1, nsent: 1, exp_lvl: 1'b1};

      do_reset();
      check_idle("reset");

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Sticky underrun from the last row must clear on reset
      do_reset();
      check_idle("err_clr");

      // Back-to-back bursts with pkt_req held high
      cfg_lpx = '0; cfg_hs_prep = '0; cfg_hs_zero = '0; cfg_hs_trail = '0;
      log_q.delete();
      @(negedge clk);
      bus.in_beat.data = 8'h5A; bus.in_beat.last = 1'b1; bus.in_valid = 1'b1;
      pkt_req = 1'b1; log_en = 1'b1;
      repeat (160) @(negedge clk);
      log_en = 1'b0; pkt_req = 1'b0; bus.in_valid = 1'b0;
      rises = 0; i1 = -1; j = -1;
      for (int i = 1; i < log_q.size(); i++) begin
         if (log_q[i].busy && !log_q[i-1].busy) rises++;
         if (i1 < 0 && log_q[i-1].busy && !log_q[i].busy) i1 = i;
         if (j < 0 && log_q[i-1].oe && log_q[i].lp == 2'b11) j = i;
      end
      lowlen = 0;
      if (i1 >= 0) for (int i = i1; i < log_q.size() && !log_q[i].busy; i++) lowlen++;
      lp11len = 0;
      if (j >= 0) for (int i = j; i < log_q.size() && log_q[i].lp == 2'b11; i++) lp11len++;
      i0 = (rises >= 1) ? 1 : 0;
      check("b2b_second_burst", i0, 1);
      check("b2b_busy_low_len", lowlen, 1);
      check("b2b_lp11_len", lp11len, 1);

      // Reset in the middle of HS_DATA
      do_reset();
      @(negedge clk);
      bus.in_beat.data = 8'h33; bus.in_beat.last = 1'b0; bus.in_valid = 1'b1;
      pkt_req = 1'b1;
      for (int c = 0; c < 100 && !bus.in_ready; c++) @(negedge clk);
      check("mid_rst_fetch_seen", int'(bus.in_ready), 1);
      repeat (3) @(negedge clk);
      pkt_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_busy", int'(pkt_busy), 0);
      check("mid_rst_rdy", int'(bus.in_ready), 0);
      check("mid_rst_oe_lag", int'(data_hs_oe), 1);
      @(posedge clk); #1;
      check("mid_rst_oe_off", int'(data_hs_oe), 0);
      check("mid_rst_lp", int'({data_lp_p, data_lp_n}), 3);
      @(negedge clk);
      rst = 1'b0; bus.in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
